// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline stage with registered ready, flush and BUBBLE fill.
// Optional bubble counter enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [31:0] BUBBLE = 32'h00000013
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i,
  output logic [1:0]       occupancy_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]      bubble_cnt_o
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_d, ready_d;
  logic [1:0]       occ_d;
  logic             accept;
  logic             xfer_out;

  assign accept   = valid_i & ready_o;
  assign xfer_out = valid_o & ready_i;

  // Next state and entry contents; flush overrides any handshake this cycle.
  always_comb begin
    state_d = state_q;
    main_d  = data_o;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = data_i;
        end
      end
      ST_ONE: begin
        if (accept && xfer_out) begin
          main_d = data_i;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = data_i;
        end else if (xfer_out) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_W;
        end
      end
      ST_TWO: begin
        if (xfer_out) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE_W;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = BUBBLE_W;
        skid_d  = BUBBLE_W;
      end
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_W;
      skid_d  = BUBBLE_W;
    end
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_TWO);
    occ_d   = state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_EMPTY;
      data_o      <= BUBBLE_W;
      skid_q      <= BUBBLE_W;
      valid_o     <= 1'b0;
      ready_o     <= 1'b1;
      occupancy_o <= 2'd0;
    end else begin
      state_q     <= state_d;
      data_o      <= main_d;
      skid_q      <= skid_d;
      valid_o     <= valid_d;
      ready_o     <= ready_d;
      occupancy_o <= occ_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating count of cycles where downstream was ready but we had nothing.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bubble_cnt_o <= 16'd0;
    end else if (ready_i && !valid_o && (bubble_cnt_o != 16'hFFFF)) begin
      bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end
  end
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model plus directed literal checks.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic        ready_i;
  logic [1:0]  occupancy_o;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] bubble_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .occupancy_o (occupancy_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two payloads.
  logic [31:0] q[$];
  int unsigned m_bub = 0;
  bit          model_on = 0;

  always @(posedge clk) begin
    bit can_take;
    if (!rst_n) begin
      q.delete();
      m_bub    = 0;
      model_on = 1;
    end else if (model_on) begin
      if (ready_i && q.size() == 0 && m_bub < 32'hFFFF) m_bub = m_bub + 1;
      if (flush_i) begin
        q.delete();
      end else begin
        can_take = (q.size() < 2);
        if (q.size() > 0 && ready_i) void'(q.pop_front());
        if (valid_i && can_take) q.push_back(data_i);
      end
    end
  end

  // Compare DUT against the model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (model_on) begin
      chk("m_valid", {31'd0, valid_o}, {31'd0, q.size() > 0});
      chk("m_data", data_o, (q.size() > 0) ? q[0] : 32'h00000013);
      chk("m_occ", {30'd0, occupancy_o}, 32'(q.size()));
      chk("m_ready", {31'd0, ready_o}, {31'd0, q.size() < 2});
`ifdef PIPE_PERF_CNT_EN
      chk("m_bub", {16'd0, bubble_cnt_o}, m_bub);
`endif
    end
  end

  // Drive inputs at a negedge and advance to the next negedge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic r,
                     input logic f, input logic rs);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    rst_n   = rs;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 32'd0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_occ", {30'd0, occupancy_o}, 32'd0);
    chk("rst_data", data_o, 32'h00000013);

    // First payload appears one cycle after acceptance.
    cyc(1'b1, 32'h00A00093, 1'b1, 1'b0, 1'b1);
    chk("lat_valid", {31'd0, valid_o}, 32'd1);
    chk("lat_data", data_o, 32'h00A00093);
    chk("lat_occ", {30'd0, occupancy_o}, 32'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("drain_valid", {31'd0, valid_o}, 32'd0);

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b1);
      chk("stream_data", data_o, 32'(i));
      chk("stream_ready", {31'd0, ready_o}, 32'd1);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);

    // Backpressure fills both entries, then drains in order.
    cyc(1'b1, 32'hAAAA0001, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hBBBB0002, 1'b0, 1'b0, 1'b1);
    chk("bp_occ", {30'd0, occupancy_o}, 32'd2);
    chk("bp_ready", {31'd0, ready_o}, 32'd0);
    chk("bp_head", data_o, 32'hAAAA0001);
    cyc(1'b1, 32'hCCCC0003, 1'b1, 1'b0, 1'b1);
    chk("bp_second", data_o, 32'hBBBB0002);
    chk("bp_ready_after", {31'd0, ready_o}, 32'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("bp_empty", {31'd0, valid_o}, 32'd0);

    // Flush from TWO discards the held pair and the simultaneous input.
    cyc(1'b1, 32'h11110001, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h22220002, 1'b0, 1'b0, 1'b1);
    chk("fl_pre_occ", {30'd0, occupancy_o}, 32'd2);
    cyc(1'b1, 32'hC0C0C0C0, 1'b1, 1'b1, 1'b1);
    chk("fl_valid", {31'd0, valid_o}, 32'd0);
    chk("fl_data", data_o, 32'h00000013);
    chk("fl_occ", {30'd0, occupancy_o}, 32'd0);
    chk("fl_ready", {31'd0, ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      chk("fl_no_c", {31'd0, data_o == 32'hC0C0C0C0}, 32'd0);
    end

    // Reset in the middle of backpressure.
    cyc(1'b1, 32'h33330003, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h44440004, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h55550005, 1'b1, 1'b1, 1'b0);
    chk("mr_valid", {31'd0, valid_o}, 32'd0);
    chk("mr_ready", {31'd0, ready_o}, 32'd1);
    chk("mr_occ", {30'd0, occupancy_o}, 32'd0);
    chk("mr_data", data_o, 32'h00000013);
`ifdef PIPE_PERF_CNT_EN
    chk("mr_bub", {16'd0, bubble_cnt_o}, 32'd0);
`endif
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 55,
          $urandom_range(0, 99) < 4, $urandom_range(0, 199) != 0);
    end

`ifdef PIPE_PERF_CNT_EN
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("bub_sat", {16'd0, bubble_cnt_o}, 32'h0000FFFF);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("bub_hold", {16'd0, bubble_cnt_o}, 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
